// File: rtl/sram_1rw1r_param_model.sv
// 1RW+1R single-clock SRAM model with per-lane write masks, registered read ports,
// selectable read-during-write bypass on port 1 and a saturating collision counter.

// One write-mask lane: a GRAN-bit-wide slice of the whole array.
module sram_1rw1r_lane #(
    parameter int ADDR_WIDTH = 9,
    parameter int GRAN       = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  byp_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [GRAN-1:0]       wdata_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    output logic [GRAN-1:0]       rd0_o,
    output logic [GRAN-1:0]       rd1_o
);
    // No reset on the array: contents survive rst and start undefined.
    logic [GRAN-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr0_i] <= wdata_i;
    end

    assign rd0_o = mem_q[addr0_i];
    assign rd1_o = byp_i ? wdata_i : mem_q[addr1_i];
endmodule

module sram_1rw1r_param_model #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int MASK_GRAN  = 8,
    parameter int BYPASS     = 1,
    parameter int CNT_WIDTH  = 8,
    localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1,
    output logic                  collision,
    output logic [CNT_WIDTH-1:0]  coll_cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam bit                   BYP     = (BYPASS != 0);

    if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("DATA_WIDTH must be a multiple of MASK_GRAN");
    end

    logic wr_en, rd0_en, rd1_en, coll_hit;
    logic [NUM_WMASKS-1:0][MASK_GRAN-1:0] din_lanes, rd0_lanes, rd1_lanes;

    assign wr_en     = !csb0 && !web0;
    assign rd0_en    = !csb0 && web0;
    assign rd1_en    = !csb1;
    assign coll_hit  = wr_en && rd1_en && (addr0 == addr1);
    assign din_lanes = din0;

    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
        sram_1rw1r_lane #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .GRAN       (MASK_GRAN)
        ) u_lane (
            .clk     (clk),
            .we_i    (wr_en && wmask0[g]),
            .byp_i   (BYP && coll_hit && wmask0[g]),
            .addr0_i (addr0),
            .wdata_i (din_lanes[g]),
            .addr1_i (addr1),
            .rd0_o   (rd0_lanes[g]),
            .rd1_o   (rd1_lanes[g])
        );
    end

    logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                  collision_q, collision_d;
    logic [CNT_WIDTH-1:0]  coll_cnt_q, coll_cnt_d;

    always_comb begin
        dout0_d     = dout0_q;
        dout1_d     = dout1_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        collision_d = coll_hit;
        coll_cnt_d  = coll_cnt_q;
        if (rd0_en) begin
            dout0_d   = rd0_lanes;
            rvalid0_d = 1'b1;
        end
        if (rd1_en) begin
            dout1_d   = rd1_lanes;
            rvalid1_d = 1'b1;
        end
        // Saturate rather than wrap so a stuck counter still reads as "many".
        if (coll_hit && coll_cnt_q != CNT_MAX) coll_cnt_d = coll_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout0_q     <= '0;
            dout1_q     <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
        end else begin
            dout0_q     <= dout0_d;
            dout1_q     <= dout1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            collision_q <= collision_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    assign dout0     = dout0_q;
    assign dout1     = dout1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign collision = collision_q;
    assign coll_cnt  = coll_cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && ($isunknown(csb0) || $isunknown(csb1) || $isunknown(web0)))
            $error("sram_1rw1r_param_model: X on csb0/csb1/web0");
    end
`endif
endmodule

// File: tb/tb_sram_1rw1r_param_model.sv
// Directed bench: a bypass/8-bit-counter instance and a no-bypass/2-bit-counter
// instance share stimulus; expectations are queued with due cycles and popped by a monitor.

`define SB_CHK(Q, VLD, ACT, NAME) \
    if (Q.size() != 0 && Q[0].due < cyc) begin \
        total++; bad++; \
        $display("FAIL %s missing: required=%h at cycle %0d", NAME, Q[0].v, Q[0].due); \
        void'(Q.pop_front()); \
    end \
    if (VLD) begin \
        total++; \
        if (Q.size() == 0) begin \
            bad++; $display("FAIL %s unexpected: got=%h at cycle %0d", NAME, ACT, cyc); \
        end else begin \
            e_m = Q.pop_front(); \
            if (e_m.v !== 32'(ACT) || e_m.due != cyc) begin \
                bad++; \
                $display("FAIL %s: got=%h at cycle %0d required=%h at cycle %0d", NAME, ACT, cyc, e_m.v, e_m.due); \
            end \
        end \
    end

module tb_sram_1rw1r_param_model;
    logic        clk = 1'b0;
    logic        rst;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [8:0]  addr0, addr1;
    logic [31:0] din0;
    logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic        a_rvalid0, a_rvalid1, a_collision, b_rvalid0, b_rvalid1, b_collision;
    logic [7:0]  a_coll_cnt;
    logic [1:0]  b_coll_cnt;

    always #5 clk = ~clk;

    sram_1rw1r_param_model #(.BYPASS(1), .CNT_WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(a_dout0), .rvalid0(a_rvalid0), .csb1(csb1), .addr1(addr1),
        .dout1(a_dout1), .rvalid1(a_rvalid1), .collision(a_collision), .coll_cnt(a_coll_cnt));

    sram_1rw1r_param_model #(.BYPASS(0), .CNT_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(b_dout0), .rvalid0(b_rvalid0), .csb1(csb1), .addr1(addr1),
        .dout1(b_dout1), .rvalid1(b_rvalid1), .collision(b_collision), .coll_cnt(b_coll_cnt));

    typedef struct {
        logic [31:0] v;
        int          due;
    } exp_t;

    exp_t q0[$], qb0[$], q1[$], qb1[$], qc[$], qcb[$];
    exp_t e_m;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectations are due on the cycle after the edge that samples the request.
    function automatic void push0(input logic [31:0] v);
        q0.push_back('{v, cyc + 1});
        qb0.push_back('{v, cyc + 1});
    endfunction

    function automatic void push1(input logic [31:0] va, input logic [31:0] vb);
        q1.push_back('{va, cyc + 1});
        qb1.push_back('{vb, cyc + 1});
    endfunction

    function automatic void pushc(input logic [31:0] va, input logic [31:0] vb);
        qc.push_back('{va, cyc + 1});
        qcb.push_back('{vb, cyc + 1});
    endfunction

    always @(negedge clk) begin
        `SB_CHK(q0,  a_rvalid0,   a_dout0,    "a_dout0")
        `SB_CHK(qb0, b_rvalid0,   b_dout0,    "b_dout0")
        `SB_CHK(q1,  a_rvalid1,   a_dout1,    "a_dout1")
        `SB_CHK(qb1, b_rvalid1,   b_dout1,    "b_dout1")
        `SB_CHK(qc,  a_collision, a_coll_cnt, "a_coll_cnt")
        `SB_CHK(qcb, b_collision, b_coll_cnt, "b_coll_cnt")
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic op(input logic c0, input logic w0, input logic [3:0] m, input logic [8:0] a0,
                      input logic [31:0] d0, input logic c1, input logic [8:0] a1);
        csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        op(1'b0, 1'b0, m, a, d, 1'b1, 9'h0);
    endtask

    task automatic rd0(input logic [8:0] a);
        op(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b1, 9'h0);
    endtask

    task automatic rd1(input logic [8:0] a);
        op(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, a);
    endtask

    task automatic coll(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        op(1'b0, 1'b0, m, a, d, 1'b0, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b1, 9'h0);
    endtask

    initial begin
        rst = 1'b1;
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout0", a_dout0, 32'h0);
        chk("rst_dout1", a_dout1, 32'h0);
        chk("rst_rvalid0", 32'(a_rvalid0), 32'h0);
        chk("rst_rvalid1", 32'(a_rvalid1), 32'h0);
        chk("rst_collision", 32'(a_collision), 32'h0);
        chk("rst_coll_cnt", 32'(a_coll_cnt), 32'h0);
        rst = 1'b0;
        idle(3);
        chk("idle_rvalid0", 32'(a_rvalid0), 32'h0);
        chk("idle_rvalid1", 32'(a_rvalid1), 32'h0);
        chk("idle_coll_cnt", 32'(a_coll_cnt), 32'h0);

        // Full write, then each port reads it, then both ports read it together.
        wr(9'h005, 32'hDEADBEEF, 4'hF);
        push0(32'hDEADBEEF);
        rd0(9'h005);
        push1(32'hDEADBEEF, 32'hDEADBEEF);
        rd1(9'h005);
        push0(32'hDEADBEEF);
        push1(32'hDEADBEEF, 32'hDEADBEEF);
        op(1'b0, 1'b1, 4'h0, 9'h005, 32'h0, 1'b0, 9'h005);

        // Partial write on lanes 0 and 2.
        wr(9'h005, 32'h11223344, 4'b0101);
        push0(32'hDE22BE44);
        rd0(9'h005);
        wr(9'h006, 32'h0, 4'hF);
        chk("wr_holds_dout0", a_dout0, 32'hDE22BE44);
        chk("wr_no_rvalid0", 32'(a_rvalid0), 32'h0);

        // Five back-to-back collisions on 0x1FF; bypass instance sees merged data.
        wr(9'h1FF, 32'h0, 4'hF);
        push1(32'hCAFEF00D, 32'h00000000); pushc(1, 1);
        coll(9'h1FF, 32'hCAFEF00D, 4'hF);
        push1(32'hCAFE5678, 32'hCAFEF00D); pushc(2, 2);
        coll(9'h1FF, 32'h12345678, 4'b0011);
        push1(32'hCAFE5678, 32'hCAFE5678); pushc(3, 3);
        coll(9'h1FF, 32'hFFFFFFFF, 4'b0000);
        push1(32'hAAFE5678, 32'hCAFE5678); pushc(4, 3);
        coll(9'h1FF, 32'hAABBCCDD, 4'b1000);
        push1(32'hAA005678, 32'hAAFE5678); pushc(5, 3);
        coll(9'h1FF, 32'h00000000, 4'b0100);
        push0(32'hAA005678);
        rd0(9'h1FF);
        // Write and read at different addresses is not a collision.
        push1(32'hAA005678, 32'hAA005678);
        op(1'b0, 1'b0, 4'hF, 9'h1FE, 32'h0, 1'b0, 9'h1FF);
        idle(2);
        chk("a_coll_cnt_final", 32'(a_coll_cnt), 32'd5);
        chk("b_coll_cnt_sat", 32'(b_coll_cnt), 32'd3);
        chk("no_coll_pulse", 32'(a_collision), 32'h0);

        // Address-pattern fill and a full back-to-back read sweep.
        for (int i = 0; i < 512; i++) wr(9'(i), 32'(i), 4'hF);
        for (int i = 0; i < 512; i++) begin
            push0(32'(i));
            rd0(9'(i));
        end

        // Reset lands while a read is in flight; that read is dropped.
        for (int i = 0; i < 20; i++) begin
            push0(32'(i + 100));
            rd0(9'(i + 100));
            if (i == 10) begin
                #2;
                rst = 1'b1;
                #1;
                q0.delete();
                qb0.delete();
                chk("midrst_rvalid0", 32'(a_rvalid0), 32'h0);
                chk("midrst_dout0", a_dout0, 32'h0);
                chk("midrst_dout1", a_dout1, 32'h0);
                chk("midrst_coll_cnt", 32'(a_coll_cnt), 32'h0);
                csb0 = 1'b1; csb1 = 1'b1; web0 = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                break;
            end
        end
        idle(1);
        push0(32'h005);
        rd0(9'h005);
        push1(32'h1FF, 32'h1FF);
        rd1(9'h1FF);
        idle(3);

        begin
            int left;
            left = q0.size() + qb0.size() + q1.size() + qb1.size() + qc.size() + qcb.size();
            total++;
            if (left != 0) begin
                bad++;
                $display("FAIL sb_drain: got=%0d pending required=0", left);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
